instr_fetch_unit: RTL and testbench

Prefetching instruction fetch stage that sits directly upstream of the single-cycle core datapath. It replaces the core's combinational PC→instruction-memory path with a decoupled front end:
- issues sequential word fetches to instruction memory over a valid/ready request channel;
- buffers in-order responses in a small queue;
- presents `{pc, instr}` pairs to the core over a valid/ready channel.

Taken branches and jumps from the core arrive as a redirect. A redirect flushes the queue and discards stale in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_unit_queue.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_pkg
// Description : Shared types and constants for the instruction fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential next-word address; wraps naturally at 32 bits.
    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch entries with push, pop, flush and an
//               occupancy count. Flush wins over push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Prefetching fetch stage. Issues sequential word fetches under a
//               credit limit, queues in-order responses, hands {pc, instr} to
//               the core, and flushes/restarts on a redirect while discarding
//               responses that belong to the abandoned path.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;

    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W:0]   w_credit_used;
    logic [c_CNT_W-1:0] w_outstanding_next;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_req_fire;
    logic               w_keep;
    logic               w_pop;
    fetch_entry_t       w_push_data;
    fetch_entry_t       w_head;

    // Queue slots plus in-flight requests may never exceed DEPTH, so every
    // response that is kept is guaranteed a free slot.
    assign w_credit_used  = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !reset && (w_credit_used < (c_CNT_W+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Stale requests stay counted in outstanding until their response drains.
    assign w_outstanding_next = r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid);
    assign w_redirect_pc      = redirect_pc & ~32'h0000_0003;

    // A response in the redirect cycle belongs to the old path and is dropped.
    assign w_keep = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);

    assign instr_valid = !reset && (w_count != '0);
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign instr_pc    = w_head.pc;
    assign instr_data  = w_head.instr;

    assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_keep),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // PC, credit and drop tracking; redirect overrides normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_outstanding_next;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= pc_incr(r_fetch_pc);
            end
            if (w_keep) begin
                r_rsp_pc <= pc_incr(r_rsp_pc);
            end
            r_outstanding <= w_outstanding_next;
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            end
        end
    end

    a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
        r_outstanding <= c_CNT_W'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (reset)
        r_drop_cnt <= r_outstanding);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with an
//               in-order fixed-latency memory model returning addr ^ A5A5_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int          errors = 0;
    int          checks = 0;
    int unsigned ecount = 0;
    int unsigned mem_lat = 1;
    int unsigned req_count = 0;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } mreq_t;
    mreq_t mq[$];

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            ecount++;
        end
    end

    // Memory model: a request accepted at edge k answers for capture at edge k+mem_lat.
    initial begin
        mreq_t m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                imem_rsp_valid = 1'b0;
                if (mq.size() > 0 && mq[0].due == ecount + 1) begin
                    m = mq.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = m.addr ^ 32'hA5A5_0000;
                end
                if (imem_req_valid && imem_req_ready) begin
                    m.due  = ecount + 1 + mem_lat;
                    m.addr = imem_req_addr;
                    mq.push_back(m);
                    req_count++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic do_reset(input int unsigned lat);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat        = lat;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        req_count = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL reset_req_valid[%0d]: got %b expected 0", i, imem_req_valid);
            end
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++; $display("FAIL reset_instr_valid[%0d]: got %b expected 0", i, instr_valid);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req_addr !== 32'h4) begin
            errors++; $display("FAIL reset_second_cycle: got iv=%b a=%h expected iv=0 a=00000004", instr_valid, imem_req_addr);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL reset_first_instr: got iv=%b pc=%h expected iv=1 pc=00000000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        do_reset(1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_pc = 32'(4 * i);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ 32'hA5A5_0000)) begin
                errors++; $display("FAIL stream[%0d]: got iv=%b pc=%h d=%h expected iv=1 pc=%h d=%h",
                                   i, instr_valid, instr_pc, instr_data, exp_pc, exp_pc ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset(1);
        instr_ready = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (req_count != 4) begin
            errors++; $display("FAIL bp_req_count: got %0d expected 4", req_count);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_req_stalled: got %b expected 0", imem_req_valid);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_pc = 32'(4 * i);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ 32'hA5A5_0000)) begin
                errors++; $display("FAIL bp_drain[%0d]: got iv=%b pc=%h d=%h expected iv=1 pc=%h d=%h",
                                   i, instr_valid, instr_pc, instr_data, exp_pc, exp_pc ^ 32'hA5A5_0000);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset(3);
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        checks++;
        if (dut.r_outstanding !== 3'd2) begin
            errors++; $display("FAIL redir_outstanding: got %0d expected 2", dut.r_outstanding);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_addr !== 32'h100 || dut.r_drop_cnt !== 3'd2) begin
            errors++; $display("FAIL redir_after: got iv=%b a=%h drop=%0d expected iv=0 a=00000100 drop=2",
                               instr_valid, imem_req_addr, dut.r_drop_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++; $display("FAIL redir_stale_hidden[%0d]: got iv=1 pc=%h expected iv=0", i, instr_pc);
            end
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== 32'hA5A5_0100) begin
            errors++; $display("FAIL redir_first: got iv=%b pc=%h d=%h expected iv=1 pc=00000100 d=a5a50100",
                               instr_valid, instr_pc, instr_data);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
            errors++; $display("FAIL redir_second: got iv=%b pc=%h expected iv=1 pc=00000104", instr_valid, instr_pc);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1);
        repeat (3) @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            errors++; $display("FAIL simul_pre: got iv=%b pc=%h expected iv=1 pc=00000004", instr_valid, instr_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL simul_flush: got iv=%b a=%h expected iv=0 a=00000200", instr_valid, imem_req_addr);
        end
        checks++;
        if (dut.r_drop_cnt !== 3'd1 || dut.r_outstanding !== 3'd1) begin
            errors++; $display("FAIL simul_drop: got drop=%0d out=%0d expected drop=1 out=1",
                               dut.r_drop_cnt, dut.r_outstanding);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || dut.r_drop_cnt !== 3'd0) begin
            errors++; $display("FAIL simul_drained: got iv=%b drop=%0d expected iv=0 drop=0", instr_valid, dut.r_drop_cnt);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_data !== 32'hA5A5_0200) begin
            errors++; $display("FAIL simul_first: got iv=%b pc=%h d=%h expected iv=1 pc=00000200 d=a5a50200",
                               instr_valid, instr_pc, instr_data);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h204) begin
            errors++; $display("FAIL simul_second: got iv=%b pc=%h expected iv=1 pc=00000204", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got_pc [3];
        logic [31:0] got_d  [3];
        logic [31:0] exp_pc [3];
        int          n;
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        n = 0;
        do_reset(1);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (instr_valid === 1'b1) begin
                got_pc[n] = instr_pc;
                got_d[n]  = instr_data;
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL wrap_timeout: got %0d instrs expected 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_pc[i] !== exp_pc[i] || got_d[i] !== (exp_pc[i] ^ 32'hA5A5_0000)) begin
                    errors++; $display("FAIL wrap[%0d]: got pc=%h d=%h expected pc=%h d=%h",
                                       i, got_pc[i], got_d[i], exp_pc[i], exp_pc[i] ^ 32'hA5A5_0000);
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
